// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage: state encoding, PC-source codes,
// field widths, the ID/EX register layout and the saturating-counter helper.
package id_ex_stage_pkg;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 6;
  localparam int MTR_W   = 2;
  localparam int PCSRC_W = 3;
  localparam int CNT_W   = 16;

  localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = 3'b001;
  localparam logic [PCSRC_W-1:0] PCSRC_JR     = 3'b011;
  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [DATA_W-1:0]  data1;
    logic [DATA_W-1:0]  data2;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc4;
    logic               regwr;
    logic               memwr;
    logic               memrd;
    logic               alusrc1;
    logic               alusrc2;
    logic [ALUOP_W-1:0] aluop;
    logic [MTR_W-1:0]   memtoreg;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection for the instruction in ID against the ID/EX contents.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic               i_idex_memrd,
  input  logic               i_idex_regwr,
  input  logic [REG_W-1:0]   i_idex_rd,
  input  logic [REG_W-1:0]   i_id_rs,
  input  logic [REG_W-1:0]   i_id_rt,
  input  logic               i_id_uses_rt,
  input  logic [PCSRC_W-1:0] i_id_pcsrc,
  output logic               o_lu,
  output logic               o_ch,
  output logic               o_two_cycle
);
  logic w_rd_live;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_is_cmp;

  assign w_rd_live = (i_idex_rd != '0);
  assign w_rs_hit  = w_rd_live && (i_idex_rd == i_id_rs);
  assign w_rt_hit  = w_rd_live && (i_idex_rd == i_id_rt);
  assign w_is_cmp  = (i_id_pcsrc == PCSRC_BRANCH) || (i_id_pcsrc == PCSRC_JR);

  assign o_lu = i_idex_memrd && (w_rs_hit || (i_id_uses_rt && w_rt_hit));
  // Compares resolve in ID, so both source fields matter regardless of uses_rt
  assign o_ch = w_is_cmp && i_idex_regwr && (w_rs_hit || w_rt_hit);
  assign o_two_cycle = o_ch && i_idex_memrd;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall FSM and saturating stall/flush counters.
// state | meaning :  RUN | normal capture or single-cycle stall ;  HOLD | second bubble of a load feeding a compare
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   ID_rs,
  input  logic [REG_W-1:0]   ID_rt,
  input  logic [REG_W-1:0]   ID_rd,
  input  logic [DATA_W-1:0]  ID_data1,
  input  logic [DATA_W-1:0]  ID_data2,
  input  logic [DATA_W-1:0]  ID_imm,
  input  logic [DATA_W-1:0]  ID_pc4,
  input  logic               ID_regwr,
  input  logic               ID_memwr,
  input  logic               ID_memrd,
  input  logic               ID_alusrc1,
  input  logic               ID_alusrc2,
  input  logic [ALUOP_W-1:0] ID_aluop,
  input  logic [MTR_W-1:0]   ID_memtoreg,
  input  logic [PCSRC_W-1:0] ID_pcsrc,
  input  logic               ID_uses_rt,
  input  logic               flush,
  output logic [REG_W-1:0]   IDEX_rs,
  output logic [REG_W-1:0]   IDEX_rt,
  output logic [REG_W-1:0]   IDEX_rd,
  output logic [DATA_W-1:0]  IDEX_data1,
  output logic [DATA_W-1:0]  IDEX_data2,
  output logic [DATA_W-1:0]  IDEX_imm,
  output logic [DATA_W-1:0]  IDEX_pc4,
  output logic               IDEX_regwr,
  output logic               IDEX_memwr,
  output logic               IDEX_memrd,
  output logic               IDEX_alusrc1,
  output logic               IDEX_alusrc2,
  output logic [ALUOP_W-1:0] IDEX_aluop,
  output logic [MTR_W-1:0]   IDEX_memtoreg,
  output logic               stall,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);
  state_t           r_state;
  idex_t            r_idex;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  idex_t            w_id;
  logic             w_lu;
  logic             w_ch;
  logic             w_two_cycle;
  logic             w_stall;

  assign w_id = '{rs: ID_rs, rt: ID_rt, rd: ID_rd, data1: ID_data1, data2: ID_data2,
                  imm: ID_imm, pc4: ID_pc4, regwr: ID_regwr, memwr: ID_memwr,
                  memrd: ID_memrd, alusrc1: ID_alusrc1, alusrc2: ID_alusrc2,
                  aluop: ID_aluop, memtoreg: ID_memtoreg};

  hazard_detect u_hazard_detect (
    .i_idex_memrd (r_idex.memrd),
    .i_idex_regwr (r_idex.regwr),
    .i_idex_rd    (r_idex.rd),
    .i_id_rs      (ID_rs),
    .i_id_rt      (ID_rt),
    .i_id_uses_rt (ID_uses_rt),
    .i_id_pcsrc   (ID_pcsrc),
    .o_lu         (w_lu),
    .o_ch         (w_ch),
    .o_two_cycle  (w_two_cycle)
  );

  // HOLD stalls unconditionally; the bubble already in ID/EX would hide the hazard
  assign w_stall = !reset && !flush && ((r_state == ST_HOLD) || w_lu || w_ch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_idex      <= IDEX_BUBBLE;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (flush)   r_flush_cnt <= sat_inc(r_flush_cnt);
      if (flush || r_state == ST_HOLD) begin
        r_idex  <= IDEX_BUBBLE;
        r_state <= ST_RUN;
      end else if (w_lu || w_ch) begin
        r_idex  <= IDEX_BUBBLE;
        r_state <= w_two_cycle ? ST_HOLD : ST_RUN;
      end else begin
        r_idex  <= w_id;
        r_state <= ST_RUN;
      end
    end
  end

  assign stall         = w_stall;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;
  assign IDEX_rs       = r_idex.rs;
  assign IDEX_rt       = r_idex.rt;
  assign IDEX_rd       = r_idex.rd;
  assign IDEX_data1    = r_idex.data1;
  assign IDEX_data2    = r_idex.data2;
  assign IDEX_imm      = r_idex.imm;
  assign IDEX_pc4      = r_idex.pc4;
  assign IDEX_regwr    = r_idex.regwr;
  assign IDEX_memwr    = r_idex.memwr;
  assign IDEX_memrd    = r_idex.memrd;
  assign IDEX_alusrc1  = r_idex.alusrc1;
  assign IDEX_alusrc2  = r_idex.alusrc2;
  assign IDEX_aluop    = r_idex.aluop;
  assign IDEX_memtoreg = r_idex.memtoreg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: a driver queues hand-computed expectations,
// a monitor compares stall before each edge and the registered outputs after it.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct packed {
    idex_t      d;
    logic [2:0] pcsrc;
    logic       uses_rt;
  } in_t;

  typedef struct {
    string       name;
    logic        stall;
    idex_t       idex;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  localparam idex_t ZERO = '0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [31:0] id_data1 = '0, id_data2 = '0, id_imm = '0, id_pc4 = '0;
  logic id_regwr = 1'b0, id_memwr = 1'b0, id_memrd = 1'b0, id_alusrc1 = 1'b0, id_alusrc2 = 1'b0;
  logic [5:0] id_aluop = '0;
  logic [1:0] id_memtoreg = '0;
  logic [2:0] id_pcsrc = '0;
  logic id_uses_rt = 1'b0;
  logic flush = 1'b0;

  logic [4:0]  idex_rs, idex_rt, idex_rd;
  logic [31:0] idex_data1, idex_data2, idex_imm, idex_pc4;
  logic idex_regwr, idex_memwr, idex_memrd, idex_alusrc1, idex_alusrc2;
  logic [5:0]  idex_aluop;
  logic [1:0]  idex_memtoreg;
  logic        stall;
  logic [15:0] stall_cnt, flush_cnt;
  idex_t       obs;

  int n_checks = 0;
  int n_errors = 0;
  exp_t q[$];
  idex_t m_idex = '0;
  logic [15:0] m_sc = '0, m_fc = '0;
  int raw_stalls = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .ID_rs(id_rs), .ID_rt(id_rt), .ID_rd(id_rd),
    .ID_data1(id_data1), .ID_data2(id_data2), .ID_imm(id_imm), .ID_pc4(id_pc4),
    .ID_regwr(id_regwr), .ID_memwr(id_memwr), .ID_memrd(id_memrd),
    .ID_alusrc1(id_alusrc1), .ID_alusrc2(id_alusrc2),
    .ID_aluop(id_aluop), .ID_memtoreg(id_memtoreg),
    .ID_pcsrc(id_pcsrc), .ID_uses_rt(id_uses_rt), .flush(flush),
    .IDEX_rs(idex_rs), .IDEX_rt(idex_rt), .IDEX_rd(idex_rd),
    .IDEX_data1(idex_data1), .IDEX_data2(idex_data2), .IDEX_imm(idex_imm), .IDEX_pc4(idex_pc4),
    .IDEX_regwr(idex_regwr), .IDEX_memwr(idex_memwr), .IDEX_memrd(idex_memrd),
    .IDEX_alusrc1(idex_alusrc1), .IDEX_alusrc2(idex_alusrc2),
    .IDEX_aluop(idex_aluop), .IDEX_memtoreg(idex_memtoreg),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign obs = '{rs: idex_rs, rt: idex_rt, rd: idex_rd, data1: idex_data1, data2: idex_data2,
                 imm: idex_imm, pc4: idex_pc4, regwr: idex_regwr, memwr: idex_memwr,
                 memrd: idex_memrd, alusrc1: idex_alusrc1, alusrc2: idex_alusrc2,
                 aluop: idex_aluop, memtoreg: idex_memtoreg};

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic in_t mk(input int tag, input int rs, input int rt, input int rd,
                             input bit regwr, input bit memrd, input logic [2:0] pcsrc,
                             input bit uses_rt);
    in_t v;
    logic [7:0] t;
    t = 8'(tag);
    v.d.rs       = 5'(rs);
    v.d.rt       = 5'(rt);
    v.d.rd       = 5'(rd);
    v.d.data1    = 32'h1000_0000 + 32'(tag);
    v.d.data2    = 32'h2000_0000 + 32'(tag * 3);
    v.d.imm      = 32'hFFFF_0000 | 32'(tag);
    v.d.pc4      = 32'h0040_0000 + 32'(tag * 4);
    v.d.regwr    = regwr;
    v.d.memwr    = t[2];
    v.d.memrd    = memrd;
    v.d.alusrc1  = t[0];
    v.d.alusrc2  = t[1];
    v.d.aluop    = t[5:0] ^ 6'h2A;
    v.d.memtoreg = memrd ? 2'b01 : 2'b00;
    v.pcsrc      = pcsrc;
    v.uses_rt    = uses_rt;
    return v;
  endfunction

  task automatic chk(input string nm, input bit ok, input string detail);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: %s", nm, detail);
    end
  endtask

  task automatic drive_push(input string nm, input in_t v, input bit fl, input bit es);
    exp_t e;
    id_rs = v.d.rs; id_rt = v.d.rt; id_rd = v.d.rd;
    id_data1 = v.d.data1; id_data2 = v.d.data2; id_imm = v.d.imm; id_pc4 = v.d.pc4;
    id_regwr = v.d.regwr; id_memwr = v.d.memwr; id_memrd = v.d.memrd;
    id_alusrc1 = v.d.alusrc1; id_alusrc2 = v.d.alusrc2;
    id_aluop = v.d.aluop; id_memtoreg = v.d.memtoreg;
    id_pcsrc = v.pcsrc; id_uses_rt = v.uses_rt; flush = fl;
    if (es) begin
      m_sc = sat16(m_sc);
      raw_stalls++;
    end
    if (fl) m_fc = sat16(m_fc);
    m_idex = (es || fl) ? ZERO : v.d;
    e.name = nm; e.stall = es; e.idex = m_idex; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);
  endtask

  task automatic cyc(input string nm, input in_t v, input bit fl, input bit es);
    @(negedge clk);
    drive_push(nm, v, fl, es);
  endtask

  // Monitor: stall is checked late in the low phase, registers just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q[0];
        chk({"stall ", e.name}, stall === e.stall,
            $sformatf("got %0b want %0b", stall, e.stall));
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({"idex ", e.name}, obs === e.idex,
            $sformatf("got %h want %h", obs, e.idex));
        chk({"stall_cnt ", e.name}, stall_cnt === e.sc,
            $sformatf("got %h want %h", stall_cnt, e.sc));
        chk({"flush_cnt ", e.name}, flush_cnt === e.fc,
            $sformatf("got %h want %h", flush_cnt, e.fc));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_reset_state(input string nm);
    chk({nm, " idex"}, obs === ZERO, $sformatf("got %h want 0", obs));
    chk({nm, " stall"}, stall === 1'b0, $sformatf("got %0b want 0", stall));
    chk({nm, " stall_cnt"}, stall_cnt === 16'h0, $sformatf("got %h want 0", stall_cnt));
    chk({nm, " flush_cnt"}, flush_cnt === 16'h0, $sformatf("got %h want 0", flush_cnt));
  endtask

  initial begin
    in_t lw_a, add_a, add_b, beq_a, lw_b, add_c, jr_a, add_d, j_a, lw_c, addi_a, lw_d, add_e;
    in_t lw_z, add_z, beq_z, lw_e, beq_b, add_f, lw_f, add_g, lw_g, beq_c, x;
    lw_a   = mk(1,  1, 8, 8, 1, 1, 3'b000, 0);
    add_a  = mk(2,  8, 2, 3, 1, 0, 3'b000, 1);
    add_b  = mk(3,  4, 5, 9, 1, 0, 3'b000, 1);
    beq_a  = mk(4,  9, 0, 0, 0, 0, 3'b001, 1);
    lw_b   = mk(5,  1, 9, 9, 1, 1, 3'b000, 0);
    add_c  = mk(6,  2, 3, 10, 1, 0, 3'b000, 1);
    jr_a   = mk(7,  0, 10, 0, 0, 0, 3'b011, 0);
    add_d  = mk(8,  2, 3, 11, 1, 0, 3'b000, 1);
    j_a    = mk(9,  11, 11, 0, 0, 0, 3'b010, 0);
    lw_c   = mk(10, 1, 12, 12, 1, 1, 3'b000, 0);
    addi_a = mk(11, 1, 12, 12, 1, 0, 3'b000, 0);
    lw_d   = mk(12, 0, 13, 13, 1, 1, 3'b000, 0);
    add_e  = mk(13, 1, 13, 3, 1, 0, 3'b000, 1);
    lw_z   = mk(14, 0, 0, 0, 1, 1, 3'b000, 0);
    add_z  = mk(15, 0, 0, 0, 1, 0, 3'b000, 1);
    beq_z  = mk(16, 0, 0, 0, 0, 0, 3'b001, 1);
    lw_e   = mk(17, 1, 14, 14, 1, 1, 3'b000, 0);
    beq_b  = mk(18, 14, 0, 0, 0, 0, 3'b001, 1);
    add_f  = mk(19, 14, 14, 5, 1, 0, 3'b000, 1);
    lw_f   = mk(20, 2, 15, 15, 1, 1, 3'b000, 0);
    add_g  = mk(21, 15, 2, 6, 1, 0, 3'b000, 1);
    lw_g   = mk(22, 3, 16, 16, 1, 1, 3'b000, 0);
    beq_c  = mk(23, 16, 0, 0, 0, 0, 3'b001, 1);
    x      = mk(24, 20, 0, 20, 1, 1, 3'b001, 0);

    #7;
    check_reset_state("power-on reset");
    @(negedge clk);
    reset = 1'b0;

    // load-use on rs: one bubble then capture
    cyc("lw8",           lw_a,  0, 0);
    cyc("add lu stall",  add_a, 0, 1);
    cyc("add capture",   add_a, 0, 0);
    // compare hazard against an ALU producer: single stall
    cyc("add9",          add_b, 0, 0);
    cyc("beq ch stall",  beq_a, 0, 1);
    cyc("beq capture",   beq_a, 0, 0);
    // compare hazard against a load: two stalls via HOLD
    cyc("lw9",           lw_b,  0, 0);
    cyc("beq lw stall1", beq_a, 0, 1);
    cyc("beq lw stall2", beq_a, 0, 1);
    cyc("beq lw capt",   beq_a, 0, 0);
    // jr compares on rt even when uses_rt is clear
    cyc("add10",         add_c, 0, 0);
    cyc("jr rt stall",   jr_a,  0, 1);
    cyc("jr capture",    jr_a,  0, 0);
    // plain jump code is not a compare
    cyc("add11",         add_d, 0, 0);
    cyc("j no stall",    j_a,   0, 0);
    // rt match ignored without uses_rt, honoured with it
    cyc("lw12",          lw_c,  0, 0);
    cyc("addi no stall", addi_a, 0, 0);
    cyc("lw13",          lw_d,  0, 0);
    cyc("add rt stall",  add_e, 0, 1);
    cyc("add rt capt",   add_e, 0, 0);
    // destination register 0 never stalls
    cyc("lw0",           lw_z,  0, 0);
    cyc("add r0",        add_z, 0, 0);
    cyc("beq r0",        beq_z, 0, 0);
    // flush while in HOLD, then flush over a RUN hazard
    cyc("lw14",          lw_e,  0, 0);
    cyc("beq hold",      beq_b, 0, 1);
    cyc("flush in hold", beq_b, 1, 0);
    cyc("after flush",   add_f, 0, 0);
    cyc("lw15",          lw_f,  0, 0);
    cyc("flush over lu", add_g, 1, 0);
    cyc("add after fl",  add_g, 0, 0);
    // reset in the middle of HOLD
    cyc("lw16",          lw_g,  0, 0);
    cyc("beq to hold",   beq_c, 0, 1);
    @(posedge clk);
    #2;
    @(negedge clk);
    #1;
    chk("hold stall before reset", stall === 1'b1, $sformatf("got %0b want 1", stall));
    reset = 1'b1;
    #1;
    check_reset_state("reset in hold");
    @(posedge clk);
    #1;
    check_reset_state("reset across edge");
    @(negedge clk);
    reset = 1'b0;
    m_sc = '0;
    m_fc = '0;
    raw_stalls = 0;
    drive_push("first after reset", beq_c, 0, 0);

    // stall counter saturation
    cyc("sat seed", x, 0, 0);
    while (raw_stalls < 65540) begin
      cyc("sat stall1", x, 0, 1);
      cyc("sat stall2", x, 0, 1);
      cyc("sat capt",   x, 0, 0);
    end
    chk("sat model", m_sc === 16'hFFFF, $sformatf("got %h want ffff", m_sc));

    repeat (2) @(posedge clk);
    #2;
    chk("queue drained", q.size() == 0, $sformatf("got %0d want 0", q.size()));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 ID_rs, ID_rt, ID_rd  in  5 each  decoded register numbers (ID_rd = final write destination).
REQ-004 ID_data1, ID_data2, ID_imm, ID_pc4  in  32 each  register-file operands, extended immediate, PC+4.
REQ-005 ID_regwr, ID_memwr, ID_memrd, ID_alusrc1, ID_alusrc2  in  1 each  decoded controls.
REQ-006 ID_aluop  in  6; ID_memtoreg  in  2  ALU function and writeback-select controls.
REQ-007 ID_pcsrc  in  3  PC source of the instruction in ID (001 = branch, 011 = jump-register).
REQ-008 ID_uses_rt  in  1  instruction in ID reads rt as a source.
REQ-009 flush  in  1  taken branch/jump kills the instruction in ID.
REQ-010 IDEX_* (rs, rt, rd, data1, data2, imm, pc4, regwr, memwr, memrd, alusrc1, alusrc2, aluop, memtoreg)  out  widths as inputs  registered ID/EX contents, fed to the forwarding unit and EX.
REQ-011 stall  out  1  hold PC and IF/ID this cycle.
REQ-012 stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-013 Load-use hazard (LU) SHALL be IDEX_memrd && IDEX_rd!=0 && (IDEX_rd==ID_rs || (ID_uses_rt && IDEX_rd==ID_rt)).
REQ-014 Compare hazard (CH) SHALL be ID_pcsrc in {001,011} && IDEX_regwr && IDEX_rd!=0 && (IDEX_rd==ID_rs || IDEX_rd==ID_rt).
REQ-015 FSM states RUN and HOLD; reset state RUN.
REQ-016 In RUN with flush=0 and (LU or CH): stall=1, bubble loaded into ID/EX; next state HOLD if CH && IDEX_memrd, else RUN.
REQ-017 In HOLD with flush=0: stall=1, bubble loaded, next state RUN unconditionally (no hazard re-evaluation).
REQ-018 In RUN with no hazard and flush=0: stall=0, all ID_* values captured into IDEX_* next edge.
REQ-019 Bubble SHALL clear every IDEX_* output to 0 (all controls inactive, register numbers 0).
REQ-020 Priority per cycle: reset > flush > stall > normal capture.
REQ-021 flush=1 in any state: stall=0, bubble loaded, next state RUN; coincident hazard ignored.
REQ-022 stall_cnt SHALL increment on each cycle with stall=1; flush_cnt on each cycle with flush=1; both hold at 16'hFFFF.
REQ-023 stall SHALL be combinational from current state and current inputs (zero-cycle latency); all other outputs registered.
REQ-024 Register 0 as destination SHALL never cause a stall.

Reset
REQ-025 Reset SHALL force state RUN, all IDEX_* to 0, stall_cnt and flush_cnt to 0, and stall to 0 while reset is high.
REQ-026 Reset asserted mid-HOLD SHALL abort the stall; the first cycle after release is RUN.

Structure
REQ-027 Shared package SHALL hold FSM state encoding, pcsrc codes (PCSRC_BRANCH=3'b001, PCSRC_JR=3'b011), bubble constant widths, counter width 16.
REQ-028 One sub-module hazard_detect SHALL compute LU, CH and the two-cycle flag combinationally; FSM, pipeline register and counters stay in id_ex_stage.

Verification
REQ-029 lw $8 in IDEX (memrd=1, rd=8), add reading rs=8 in ID -> stall=1 one cycle, IDEX_regwr=0 next edge, add captured the following edge.
REQ-030 add writing rd=9 in IDEX, beq rs=9 in ID -> stall=1 one cycle, state stays RUN; lw rd=9 instead -> stall=1 two consecutive cycles via HOLD.
REQ-031 lw rd=0 in IDEX, ID reads rs=0 -> stall=0, normal capture.
REQ-032 State HOLD with flush=1 -> stall=0, bubble loaded, state RUN next cycle, flush_cnt+1.
REQ-033 Reset pulse during HOLD -> all IDEX_* = 0 and stall=0 immediately; stall_cnt=0.
REQ-034 Force 65 540 stall cycles -> stall_cnt reads 16'hFFFF and stays.
